// File: rtl/imem_wb_responder_pkg.sv
// Shared parameters, FSM encoding and address helpers for the instruction
// memory Wishbone responder and its line buffer.
package imem_wb_responder_pkg;

  localparam int RW         = 16;
  localparam int LINE_BEATS = 8;
  localparam int BEAT_W     = 3;
  localparam int TAG_W      = RW - BEAT_W;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Line tag of a word address.
  function automatic logic [TAG_W-1:0] line_tag(input logic [RW-1:0] adr);
    return adr[RW-1:BEAT_W];
  endfunction

  // Beat index of a word address within its line.
  function automatic logic [BEAT_W-1:0] line_beat(input logic [RW-1:0] adr);
    return adr[BEAT_W-1:0];
  endfunction

endpackage

// File: rtl/imem_line_buf.sv
// One-line buffer: tag register, per-beat valid bits and 8x16 beat storage
// with a single write port and an asynchronous read port.
module imem_line_buf
  import imem_wb_responder_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  inv,
  input  logic                  load,
  input  logic [TAG_W-1:0]      load_tag,
  input  logic                  wr_en,
  input  logic [BEAT_W-1:0]     wr_beat,
  input  logic [RW-1:0]         wr_data,
  input  logic                  wr_valid,
  input  logic [BEAT_W-1:0]     rd_beat,
  output logic [RW-1:0]         rd_data,
  output logic [TAG_W-1:0]      tag,
  output logic [LINE_BEATS-1:0] valid
);

  logic [RW-1:0] data_q [LINE_BEATS];

  // Tag and valid bits; invalidate or a new line load clears every beat and
  // takes priority over a same-cycle beat write.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tag   <= '0;
      valid <= '0;
    end else begin
      if (load) tag <= load_tag;
      if (inv || load) valid <= '0;
      else if (wr_en)  valid[wr_beat] <= wr_valid;
    end
  end

  // Beat storage.
  // NOTE: the data array has no reset; the valid bits already make stale
  // contents unobservable, and a reset would prevent RAM inference.
  always_ff @(posedge i_clk) begin
    if (wr_en) data_q[wr_beat] <= wr_data;
  end

  assign rd_data = data_q[rd_beat];

endmodule

// File: rtl/imem_wb_responder.sv
// Wishbone classic responder serving 8-beat line refills from a one-line
// buffer backed by a variable-latency memory port. Writes are forwarded to
// the backing memory and kept coherent in the buffer.
module imem_wb_responder
  import imem_wb_responder_pkg::*;
#(
  parameter logic [RW-1:0] ADDR_HI = 16'hF000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          wb_cyc,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  logic [RW-1:0] wb_adr,
  input  logic [RW-1:0] wb_i_dat,
  input  logic [1:0]    wb_sel,
  output logic [RW-1:0] wb_o_dat,
  output logic          wb_ack,
  output logic          wb_err,
  input  logic          buf_inv,
  output logic          mem_req,
  output logic [RW-1:0] mem_addr,
  output logic          mem_we,
  output logic [RW-1:0] mem_wdata,
  output logic [1:0]    mem_sel,
  input  logic [RW-1:0] mem_rdata,
  input  logic          mem_ack
);

  state_t              state;
  logic [BEAT_W-1:0]   cnt;
  logic                aborting;
  logic                ack_q;
  logic                err_q;

  logic [TAG_W-1:0]      req_tag;
  logic [BEAT_W-1:0]     req_beat;
  logic                  req_rd;
  logic                  unmapped;
  logic                  req_hit;

  logic [RW-1:0]         buf_rd_data;
  logic [TAG_W-1:0]      buf_tag;
  logic [LINE_BEATS-1:0] buf_valid;
  logic                  buf_load;
  logic                  buf_wr;
  logic [BEAT_W-1:0]     buf_wr_beat;
  logic [RW-1:0]         buf_wr_data;
  logic                  buf_wr_valid;

  logic                  fill_serve;
  logic                  fill_from_buf;
  logic                  fill_from_mem;
  logic                  fill_done;

  assign req_tag  = line_tag(wb_adr);
  assign req_beat = line_beat(wb_adr);
  assign req_rd   = wb_cyc && wb_stb && !wb_we;
  assign unmapped = (wb_adr >= ADDR_HI);
  assign req_hit  = (req_tag == buf_tag) && buf_valid[req_beat] && !buf_inv;

  // A read waiting on the line being filled is answered from the buffer or
  // straight from the returning beat; the fill ends after beat 7 or early
  // once an invalidate has been seen.
  assign fill_serve    = (state == ST_FILL) && req_rd && !ack_q && !unmapped &&
                         (req_tag == buf_tag) && !buf_inv && !aborting;
  assign fill_from_buf = fill_serve && buf_valid[req_beat];
  assign fill_from_mem = fill_serve && !buf_valid[req_beat] && mem_ack && (cnt == req_beat);
  assign fill_done     = (state == ST_FILL) && mem_ack &&
                         (buf_inv || aborting || (cnt == LAST_BEAT));

  // Ack and error never show while the master has dropped the cycle.
  assign wb_ack = ack_q && wb_cyc;
  assign wb_err = err_q && wb_cyc;

  imem_line_buf u_line_buf (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .inv      (buf_inv),
    .load     (buf_load),
    .load_tag (req_tag),
    .wr_en    (buf_wr),
    .wr_beat  (buf_wr_beat),
    .wr_data  (buf_wr_data),
    .wr_valid (buf_wr_valid),
    .rd_beat  (req_beat),
    .rd_data  (buf_rd_data),
    .tag      (buf_tag),
    .valid    (buf_valid)
  );

  // Buffer control: load a new line on a read miss, store fill beats, and
  // mirror completed writes that land in the buffered line.
  // NOTE: every always_comb output gets a default first so no path through
  // the case leaves a signal unassigned and infers a latch.
  always_comb begin
    buf_load     = 1'b0;
    buf_wr       = 1'b0;
    buf_wr_beat  = cnt;
    buf_wr_data  = mem_rdata;
    buf_wr_valid = 1'b1;
    case (state)
      ST_IDLE:  buf_load = wb_cyc && wb_stb && !wb_we && !unmapped && !req_hit;
      ST_FILL:  buf_wr   = mem_ack && !aborting && !buf_inv;
      ST_WRITE: begin
        if (mem_ack && (line_tag(mem_addr) == buf_tag)) begin
          buf_wr       = 1'b1;
          buf_wr_beat  = line_beat(mem_addr);
          buf_wr_data  = mem_wdata;
          buf_wr_valid = (mem_sel == 2'b11);
        end
      end
      default: ;
    endcase
  end

  // Main FSM with registered Wishbone and backing-port outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      aborting  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      wb_o_dat  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      mem_sel   <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (wb_cyc && wb_stb) begin
            if (unmapped) begin
              err_q <= 1'b1;
              state <= ST_RESP;
            end else if (wb_we) begin
              mem_req   <= 1'b1;
              mem_we    <= 1'b1;
              mem_addr  <= wb_adr;
              mem_wdata <= wb_i_dat;
              mem_sel   <= wb_sel;
              state     <= ST_WRITE;
            end else if (req_hit) begin
              ack_q    <= 1'b1;
              wb_o_dat <= buf_rd_data;
              state    <= ST_RESP;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_sel  <= 2'b11;
              mem_addr <= {req_tag, {BEAT_W{1'b0}}};
              cnt      <= '0;
              aborting <= 1'b0;
              state    <= ST_FILL;
            end
          end
        end

        ST_FILL: begin
          if (buf_inv) aborting <= 1'b1;
          if (fill_from_buf) begin
            ack_q    <= 1'b1;
            wb_o_dat <= buf_rd_data;
          end else if (fill_from_mem) begin
            ack_q    <= 1'b1;
            wb_o_dat <= mem_rdata;
          end
          if (fill_done) begin
            mem_req  <= 1'b0;
            aborting <= 1'b0;
            state    <= (fill_from_buf || fill_from_mem) ? ST_RESP : ST_IDLE;
          end else if (mem_ack) begin
            cnt      <= BEAT_W'(cnt + 1'b1);
            mem_addr <= {buf_tag, BEAT_W'(cnt + 1'b1)};
          end
        end

        ST_WRITE: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (wb_cyc && wb_stb) begin
              ack_q <= 1'b1;
              state <= ST_RESP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end

        ST_RESP: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
